// File: rtl/reg_transfer_bank_if.sv
// Command, read-port and handshake bundle for reg_transfer_bank.
// The master drives commands and Rd_Addr. The slave returns Q, Busy and Done.
interface reg_transfer_bank_if #(
  parameter int WIDTH  = 3,
  parameter int ADDR_W = 2
);
  logic              Start;
  logic [1:0]        Op;
  logic [ADDR_W-1:0] Src;
  logic [ADDR_W-1:0] Dst;
  logic [WIDTH-1:0]  D;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [WIDTH-1:0]  Q;
  logic              Busy;
  logic              Done;

  modport master (
    output Start, Op, Src, Dst, D, Rd_Addr,
    input  Q, Busy, Done
  );

  modport slave (
    input  Start, Op, Src, Dst, D, Rd_Addr,
    output Q, Busy, Done
  );
endinterface

// File: rtl/reg_transfer_bank.sv
// Register bank: LOAD, MOVE and CLEAR finish in 1 cycle; SWAP takes 3 edges through TMP. Start is ignored while Busy.
// Q is combinational; defining REG_BYPASS_EN forwards the value being written this cycle to Q.
module reg_transfer_bank #(
  parameter int WIDTH  = 3,
  parameter int ADDR_W = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  reg_transfer_bank_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_MOVE  = 2'b01,
    OP_SWAP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SW1  = 2'b01,
    SW2  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [WIDTH-1:0]  tmp_q, tmp_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  q_rd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tmp_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tmp_q   <= tmp_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  // At most one bank register is written per edge, so writes never collide.
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    tmp_d   = tmp_q;
    src_d   = src_q;
    dst_d   = dst_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          unique case (op_e'(bus.Op))
            OP_LOAD: begin
              regs_d[bus.Dst] = bus.D;
              done_d          = 1'b1;
            end
            OP_MOVE: begin
              regs_d[bus.Dst] = regs_q[bus.Src];
              done_d          = 1'b1;
            end
            OP_CLEAR: begin
              regs_d[bus.Dst] = '0;
              done_d          = 1'b1;
            end
            OP_SWAP: begin
              tmp_d   = regs_q[bus.Dst];
              src_d   = bus.Src;
              dst_d   = bus.Dst;
              state_d = SW1;
            end
            default: ;
          endcase
        end
      end
      SW1: begin
        regs_d[dst_q] = regs_q[src_q];
        state_d       = SW2;
      end
      SW2: begin
        regs_d[src_q] = tmp_q;
        state_d       = IDLE;
        done_d        = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_rd = regs_q[bus.Rd_Addr];
`ifdef REG_BYPASS_EN
    // Forward only writes that land in the bank. SWAP accept writes TMP alone.
    unique case (state_q)
      IDLE: begin
        if (bus.Start && bus.Dst == bus.Rd_Addr) begin
          unique case (op_e'(bus.Op))
            OP_LOAD:  q_rd = bus.D;
            OP_MOVE:  q_rd = regs_q[bus.Src];
            OP_CLEAR: q_rd = '0;
            default:  ;
          endcase
        end
      end
      SW1:     if (dst_q == bus.Rd_Addr) q_rd = regs_q[src_q];
      SW2:     if (src_q == bus.Rd_Addr) q_rd = tmp_q;
      default: ;
    endcase
`endif
  end

  assign bus.Q    = q_rd;
  assign bus.Busy = (state_q != IDLE);
  assign bus.Done = done_q;
endmodule

// File: tb/tb_reg_transfer_bank.sv
// Directed vector bench for reg_transfer_bank. It also covers reset during a SWAP and the read-port forwarding.
module tb_reg_transfer_bank;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reg_transfer_bank_if #(.WIDTH(3), .ADDR_W(2)) bus ();

  reg_transfer_bank #(.WIDTH(3), .ADDR_W(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] LD = 2'b00, MV = 2'b01, SW = 2'b10, CL = 2'b11;

  // Inputs are applied after a falling edge. Outputs are sampled 1 ns later, before the next rising edge.
  typedef struct {
    logic       start;
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [2:0] d;
    logic [1:0] rd;
    logic [2:0] q;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic s, logic [1:0] op, logic [1:0] src, logic [1:0] dst,
                              logic [2:0] d, logic [1:0] rd, logic [2:0] q, logic b, logic dn);
    vec_t v;
    v.start = s; v.op = op; v.src = src; v.dst = dst; v.d = d;
    v.rd = rd; v.q = q; v.busy = b; v.done = dn;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic [1:0] op, logic [1:0] src, logic [1:0] dst,
                       logic [2:0] d, logic [1:0] rd);
    bus.Start = s; bus.Op = op; bus.Src = src; bus.Dst = dst; bus.D = d; bus.Rd_Addr = rd;
  endtask

  initial begin
    drive(0, LD, 0, 0, 0, 0);

    // Bench register model: r0..r3 on the left, ignoring whether forwarding is built in.
    // Load r1 = 010. Done pulses once and Busy stays low.
    vq.push_back(mk(1, LD, 0, 1, 3'b010, 0, 3'b000, 0, 0));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 1, 3'b010, 0, 1));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 1, 3'b010, 0, 0));
    // Load r0 = 101 and r2 = 011, then SWAP r0 and r2 (the accept edge writes only TMP).
    vq.push_back(mk(1, LD, 0, 0, 3'b101, 1, 3'b010, 0, 0));
    vq.push_back(mk(1, LD, 0, 2, 3'b011, 0, 3'b101, 0, 1));
    vq.push_back(mk(1, SW, 0, 2, 3'b000, 2, 3'b011, 0, 1));
    // SW1: LOAD r3 is ignored, and changing Src/Dst has no effect.
    vq.push_back(mk(1, LD, 1, 3, 3'b111, 3, 3'b000, 1, 0));
    // SW2: r2 already holds the old r0.
    vq.push_back(mk(1, LD, 1, 3, 3'b111, 2, 3'b101, 1, 0));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 0, 3'b011, 0, 1));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 3, 3'b000, 0, 0));
    // MOVE r0 to r1, then CLEAR r0 on the next edge. Done stays high for two cycles.
    vq.push_back(mk(1, MV, 0, 1, 3'b000, 2, 3'b101, 0, 0));
    vq.push_back(mk(1, CL, 0, 0, 3'b000, 1, 3'b011, 0, 1));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 0, 3'b000, 0, 1));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 1, 3'b011, 0, 0));
    // MOVE with Src equal to Dst leaves r2 unchanged.
    vq.push_back(mk(1, MV, 2, 2, 3'b000, 3, 3'b000, 0, 0));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 2, 3'b101, 0, 1));
    // SWAP with Src equal to Dst runs all 3 edges and leaves r1 unchanged.
    vq.push_back(mk(1, SW, 1, 1, 3'b000, 0, 3'b000, 0, 0));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 1, 3'b011, 1, 0));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 1, 3'b011, 1, 0));
    // A new command is accepted on the first edge after the SWAP completes.
    vq.push_back(mk(1, LD, 0, 3, 3'b110, 1, 3'b011, 0, 1));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 3, 3'b110, 0, 1));
    vq.push_back(mk(0, LD, 0, 0, 3'b000, 2, 3'b101, 0, 0));

    // Reset state.
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.Rd_Addr = 2'(a);
      #1 check($sformatf("reset r%0d", a), 32'(bus.Q), 32'd0);
    end
    check("reset busy", 32'(bus.Busy), 32'd0);
    check("reset done", 32'(bus.Done), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge CLK);
      drive(vq[i].start, vq[i].op, vq[i].src, vq[i].dst, vq[i].d, vq[i].rd);
      #1;
      check($sformatf("v%0d q", i), 32'(bus.Q), 32'(vq[i].q));
      check($sformatf("v%0d busy", i), 32'(bus.Busy), 32'(vq[i].busy));
      check($sformatf("v%0d done", i), 32'(bus.Done), 32'(vq[i].done));
    end

    // Reset during SWAP r3 with r0 (r3 = 110, r0 = 000), asserted in SW2 before the last write.
    @(negedge CLK);
    drive(1, SW, 3, 0, 0, 0);
    @(negedge CLK);
    drive(0, LD, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    check("midswap r0", 32'(bus.Q), 32'b110);
    check("midswap busy", 32'(bus.Busy), 32'd1);
    RST_N = 1'b0;
    #1;
    check("arst busy", 32'(bus.Busy), 32'd0);
    check("arst done", 32'(bus.Done), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus.Rd_Addr = 2'(a);
      #1 check($sformatf("arst r%0d", a), 32'(bus.Q), 32'd0);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.Rd_Addr = 2'(a);
      #1 check($sformatf("post r%0d", a), 32'(bus.Q), 32'd0);
    end
    check("post busy", 32'(bus.Busy), 32'd0);
    check("post done", 32'(bus.Done), 32'd0);

    // Read r2 while a LOAD to r2 is pending. Forwarding changes only the pre-edge value.
    @(negedge CLK);
    drive(1, LD, 0, 2, 3'b001, 0);
    @(negedge CLK);
    drive(1, LD, 0, 2, 3'b110, 2);
    #1;
`ifdef REG_BYPASS_EN
    check("fwd pre-edge", 32'(bus.Q), 32'b110);
`else
    check("fwd pre-edge", 32'(bus.Q), 32'b001);
`endif
    @(negedge CLK);
    drive(0, LD, 0, 0, 0, 2);
    #1;
    check("fwd post-edge", 32'(bus.Q), 32'b110);
    check("fwd done", 32'(bus.Done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
